// File: rtl/ysyx_22050710_dmem_responder.sv
// rtl/ysyx_22050710_dmem_responder.sv - byte-writable data memory with valid/ready response and latency model
// One request outstanding; the response register is loaded at the accept edge.
module ysyx_22050710_dmem_responder #(
  parameter int                      SRAM_ADDR_WD = 32,
  parameter int                      SRAM_DATA_WD = 64,
  parameter int                      DEPTH_LOG2   = 10,
  parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter int                      LATENCY      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_wen,
  input  logic [SRAM_ADDR_WD-1:0]   i_req_addr,
  input  logic [SRAM_DATA_WD/8-1:0] i_req_wstrb,
  input  logic [SRAM_DATA_WD-1:0]   i_req_wdata,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [SRAM_DATA_WD-1:0]   o_resp_rdata,
  output logic                      o_resp_err
);

  localparam int         STRB_WD  = SRAM_DATA_WD / 8;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [2:0]              cnt_q;
  logic                    resp_valid_q;
  logic [SRAM_DATA_WD-1:0] rdata_q;
  logic                    err_q;
  logic [SRAM_DATA_WD-1:0] mem_q [DEPTH];

  logic [SRAM_ADDR_WD-1:0] offset;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   index;
  logic                    req_ready;
  logic                    accept;

  // Modular subtraction makes addresses below the base wrap to a huge offset.
  assign offset    = i_req_addr - BASE_ADDR;
  assign in_range  = (offset >> (DEPTH_LOG2 + 3)) == '0;
  assign index     = offset[DEPTH_LOG2+2:3];
  assign req_ready = !i_rst && ((state_q == IDLE) || ((state_q == RESP) && i_resp_ready));
  assign accept    = i_req_valid && req_ready;

  assign o_req_ready  = req_ready;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

  // Array contents survive reset; accept is already gated by reset.
  always_ff @(posedge i_clk) begin
    if (accept && i_req_wen && in_range) begin
      for (int b = 0; b < STRB_WD; b++) begin
        if (i_req_wstrb[b]) begin
          mem_q[index][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == 3'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          if ((state_q == RESP) && i_resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
          // A new accept overrides the retire above, so RESP can chain back-to-back.
          if (accept) begin
            rdata_q <= (!i_req_wen && in_range) ? mem_q[index] : '0;
            err_q   <= !in_range;
            cnt_q   <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q      <= BUSY;
              resp_valid_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_dmem_responder.sv
// tb/tb_ysyx_22050710_dmem_responder.sv - scoreboard bench over three latency configurations
// Instance 0: LATENCY=1, instance 1: LATENCY=3, instance 2: LATENCY=4.
module tb_ysyx_22050710_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [7:0]  req_wstrb  [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  logic [64:0] exp_q [3][$];
  logic [63:0] mdl [3][1024];
  int          resp_cnt   [3];
  int          accept_cyc [3];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_22050710_dmem_responder #(
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid[g]),
      .o_req_ready (req_ready[g]),
      .i_req_wen   (req_wen[g]),
      .i_req_addr  (req_addr[g]),
      .i_req_wstrb (req_wstrb[g]),
      .i_req_wdata (req_wdata[g]),
      .o_resp_valid(resp_valid[g]),
      .i_resp_ready(resp_ready[g]),
      .o_resp_rdata(resp_rdata[g]),
      .o_resp_err  (resp_err[g])
    );
  end

  // Scoreboard: every response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    logic [64:0] e;
    for (int i = 0; i < 3; i++) begin
      if (!rst && resp_valid[i] && resp_ready[i]) begin
        resp_cnt[i]++;
        n_checks++;
        if (exp_q[i].size() == 0) begin
          $display("FAIL resp_unexpected inst%0d got err=%b rdata=%h required no response", i, resp_err[i], resp_rdata[i]);
        end else begin
          e = exp_q[i].pop_front();
          if ({resp_err[i], resp_rdata[i]} !== e)
            $display("FAIL resp_data inst%0d got err=%b rdata=%h required err=%b rdata=%h", i, resp_err[i], resp_rdata[i], e[64], e[63:0]);
          else
            n_pass++;
        end
      end
    end
  end

  // Drives one request, waits for acceptance, updates the model and queues the expected response.
  task automatic issue(input int i, input logic wen, input logic [31:0] addr, input logic [7:0] strb, input logic [63:0] wdata);
    logic [31:0] off;
    logic        inr;
    int          idx;
    logic [63:0] rd;
    bit          ok;
    req_valid[i] = 1'b1;
    req_wen[i]   = wen;
    req_addr[i]  = addr;
    req_wstrb[i] = strb;
    req_wdata[i] = wdata;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL req_timeout inst%0d addr=%h got no accept required accept within 40 cycles", i, addr);
      req_valid[i] = 1'b0;
      return;
    end
    accept_cyc[i] = cyc;
    off = addr - 32'h8000_0000;
    inr = off < 32'h0000_2000;
    idx = int'(off[12:3]);
    rd  = 64'h0;
    if (inr && wen) begin
      for (int b = 0; b < 8; b++)
        if (strb[b]) mdl[i][idx][b*8 +: 8] = wdata[b*8 +: 8];
    end else if (inr) begin
      rd = mdl[i][idx];
    end
    exp_q[i].push_back({!inr, rd});
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    for (int k = 0; k < 50; k++) begin
      if (exp_q[i].size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q[i].size() != 0)
      $display("FAIL drain inst%0d got %0d pending required 0", i, exp_q[i].size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = 32'h0;
      req_wstrb[i] = 8'h0; req_wdata[i] = 64'h0; resp_ready[i] = 1'b1;
      resp_cnt[i] = 0; accept_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]} !== 67'h0)
        $display("FAIL reset_state inst%0d got ready=%b valid=%b err=%b rdata=%h required all 0", i, req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]);
      else
        n_pass++;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (req_ready[i] !== 1'b1)
        $display("FAIL ready_after_reset inst%0d got %b required 1", i, req_ready[i]);
      else
        n_pass++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    issue(0, 1'b1, 32'h8000_0010, 8'hFF, 64'h1122334455667788);
    n_checks++;
    if (resp_valid[0] !== 1'b1) $display("FAIL store_latency got valid=%b required 1", resp_valid[0]);
    else n_pass++;
    issue(0, 1'b0, 32'h8000_0010, 8'h00, 64'h0);
    n_checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 64'h1122334455667788)
      $display("FAIL load_basic got valid=%b rdata=%h required 1 1122334455667788", resp_valid[0], resp_rdata[0]);
    else n_pass++;
    wait_drain(0);
  endtask

  task automatic test_strobe();
    issue(0, 1'b1, 32'h8000_0010, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    issue(0, 1'b0, 32'h8000_0010, 8'h00, 64'h0);
    n_checks++;
    if (resp_rdata[0] !== 64'h11223344AAAAAAAA)
      $display("FAIL partial_strobe got %h required 11223344aaaaaaaa", resp_rdata[0]);
    else n_pass++;
    wait_drain(0);
  endtask

  task automatic test_hold();
    logic [63:0] held;
    int          base;
    bit          bad;
    resp_ready[1] = 1'b1;
    issue(1, 1'b1, 32'h8000_0010, 8'hFF, 64'hDEADBEEFCAFEF00D);
    wait_drain(1);
    resp_ready[1] = 1'b0;
    base = resp_cnt[1];
    issue(1, 1'b0, 32'h8000_0010, 8'h00, 64'h0);
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (resp_valid[1] !== (k == 3)) $display("FAIL lat3_valid cycle%0d got %b required %b", k, resp_valid[1], (k == 3));
      else n_pass++;
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    held = resp_rdata[1];
    n_checks++;
    if (held !== 64'hDEADBEEFCAFEF00D) $display("FAIL lat3_rdata got %h required deadbeefcafef00d", held);
    else n_pass++;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_rdata[1] !== held || resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bad) $display("FAIL hold_stable got valid=%b ready=%b rdata=%h required 1 0 %h", resp_valid[1], req_ready[1], resp_rdata[1], held);
    else n_pass++;
    resp_ready[1] = 1'b1;
    #1;
    n_checks++;
    if (req_ready[1] !== 1'b1) $display("FAIL ready_on_consume got %b required 1", req_ready[1]);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (resp_cnt[1] - base !== 1 || resp_valid[1] !== 1'b0)
      $display("FAIL single_response got count=%0d valid=%b required 1 0", resp_cnt[1] - base, resp_valid[1]);
    else n_pass++;
  endtask

  task automatic test_oob();
    issue(0, 1'b1, 32'h8000_0000, 8'hFF, 64'h0123456789ABCDEF);
    issue(0, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0);
    n_checks++;
    if (resp_err[0] !== 1'b1 || resp_rdata[0] !== 64'h0)
      $display("FAIL oob_wrap got err=%b rdata=%h required 1 0", resp_err[0], resp_rdata[0]);
    else n_pass++;
    issue(0, 1'b1, 32'h8000_2000, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
    issue(0, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
    n_checks++;
    if (resp_err[0] !== 1'b0 || resp_rdata[0] !== 64'h0123456789ABCDEF)
      $display("FAIL oob_no_write got err=%b rdata=%h required 0 0123456789abcdef", resp_err[0], resp_rdata[0]);
    else n_pass++;
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    int prev;
    bit bad;
    for (int k = 0; k < 4; k++)
      issue(0, 1'b1, 32'h8000_0040 + 32'(k * 8), 8'hFF, {32'hB2B0_0000 + 32'(k), 32'h5555_0000 + 32'(k * 3)});
    wait_drain(0);
    bad  = 1'b0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      issue(0, 1'b0, 32'h8000_0040 + 32'(k * 8), 8'h00, 64'h0);
      if (resp_valid[0] !== 1'b1) bad = 1'b1;
      if (k > 0 && accept_cyc[0] - prev != 1) bad = 1'b1;
      prev = accept_cyc[0];
    end
    n_checks++;
    if (bad) $display("FAIL back_to_back got gaps or missing valid required one load per cycle");
    else n_pass++;
    wait_drain(0);
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  seen;
    resp_ready[2] = 1'b1;
    issue(2, 1'b1, 32'h8000_0100, 8'hFF, 64'h5A5A5A5A12345678);
    wait_drain(2);
    issue(2, 1'b0, 32'h8000_0100, 8'h00, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready[2] !== 1'b0) $display("FAIL ready_in_reset got %b required 0", req_ready[2]);
    else n_pass++;
    rst = 1'b0;
    exp_q[2].delete();
    base = resp_cnt[2];
    #1;
    n_checks++;
    if (req_ready[2] !== 1'b1) $display("FAIL ready_after_midreset got %b required 1", req_ready[2]);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid[2] !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen || resp_cnt[2] != base) $display("FAIL discarded_response got valid seen=%b required none", seen);
    else n_pass++;
    issue(2, 1'b0, 32'h8000_0100, 8'h00, 64'h0);
    wait_drain(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_hold();
    test_oob();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
